// File: rtl/ex_stage_pkg.sv
// Shared ALU types for the execute stage: operation codes, operand selects,
// branch types and the branch-resolution helper.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_control_t;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_PC   = 2'd1,
    A_SEL_ZERO = 2'd2,
    A_SEL_RSVD = 2'd3
  } a_sel_t;

  typedef enum logic [1:0] {
    B_SEL_RS2  = 2'd0,
    B_SEL_IMM  = 2'd1,
    B_SEL_FOUR = 2'd2,
    B_SEL_RSVD = 2'd3
  } b_sel_t;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_EQ    = 3'd1,
    BR_NE    = 3'd2,
    BR_LT    = 3'd3,
    BR_GE    = 3'd4,
    BR_LTU   = 3'd5,
    BR_GEU   = 3'd6,
    BR_NONE7 = 3'd7
  } br_type_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ex_state_t;

  // Compare branches rely on the decoder issuing SLT/SLTU, so the verdict is result[0].
  function automatic logic branch_taken(br_type_t br, logic equal, logic lsb);
    logic taken;
    case (br)
      BR_EQ:   taken = equal;
      BR_NE:   taken = ~equal;
      BR_LT:   taken = lsb;
      BR_LTU:  taken = lsb;
      BR_GE:   taken = ~lsb;
      BR_GEU:  taken = ~lsb;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: arithmetic, logic, shifts and set-less-than, with zero,
// equality and signed-overflow flags.
module alu
  import ex_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  alu_control_t   ctrl,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   result,
  output logic           zero,
  output logic           equal,
  output logic           overflow
);

  localparam int SW = $clog2(N);

  logic [N-1:0]  sum_s;
  logic [N-1:0]  diff_s;
  logic [SW-1:0] shamt_s;
  logic          add_ovf_s;
  logic          sub_ovf_s;

  assign sum_s     = a + b;
  assign diff_s    = a - b;
  assign shamt_s   = b[SW-1:0];
  assign add_ovf_s = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
  assign sub_ovf_s = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
  assign zero      = (result == {N{1'b0}});
  assign equal     = (a == b);

  // Operation select and signed-overflow flag.
  always_comb begin
    result   = {N{1'b0}};
    overflow = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        result   = sum_s;
        overflow = add_ovf_s;
      end
      ALU_SUB: begin
        result   = diff_s;
        overflow = sub_ovf_s;
      end
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLL:    result = a << shamt_s;
      ALU_SRL:    result = a >> shamt_s;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt_s);
      ALU_SLT:    result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(N-1){1'b0}}, (a < b)};
      ALU_PASS_B: result = b;
      default:    result = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding-aware operand select, one ALU, branch resolution
// and a single-entry valid/ready output register with an overflow counter.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  alu_control_t in_ctrl,
  input  logic [1:0]   in_a_sel,
  input  logic [1:0]   in_b_sel,
  input  logic [4:0]   in_rs1,
  input  logic [4:0]   in_rs2,
  input  logic [4:0]   in_rd,
  input  logic [N-1:0] in_rs1_data,
  input  logic [N-1:0] in_rs2_data,
  input  logic [N-1:0] in_pc,
  input  logic [N-1:0] in_imm,
  input  logic [2:0]   in_br,
  input  logic         fwd_valid,
  input  logic [4:0]   fwd_rd,
  input  logic [N-1:0] fwd_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [4:0]   out_rd,
  output logic         out_taken,
  output logic         out_zero,
  output logic         out_equal,
  output logic         out_overflow,
  output logic [7:0]   ovf_count
);

  ex_state_t    state_r, state_next_s;
  logic [N-1:0] rs1_val_s, rs2_val_s, op_a_s, op_b_s;
  logic [N-1:0] alu_result_s;
  logic         alu_zero_s, alu_equal_s, alu_ovf_s, taken_s, accept_s;
  logic [N-1:0] out_result_r;
  logic [4:0]   out_rd_r;
  logic         out_taken_r, out_zero_r, out_equal_r, out_ovf_r;
  logic [7:0]   ovf_count_r;

  assign out_valid = (state_r == ST_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept_s  = in_valid & in_ready & ~flush;

  // Operand selection; x0 is never a forwarding target.
  always_comb begin
    rs1_val_s = in_rs1_data;
    rs2_val_s = in_rs2_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs1)) begin
      rs1_val_s = fwd_data;
    end else begin
      rs1_val_s = in_rs1_data;
    end
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs2)) begin
      rs2_val_s = fwd_data;
    end else begin
      rs2_val_s = in_rs2_data;
    end
    case (a_sel_t'(in_a_sel))
      A_SEL_RS1: op_a_s = rs1_val_s;
      A_SEL_PC:  op_a_s = in_pc;
      default:   op_a_s = {N{1'b0}};
    endcase
    case (b_sel_t'(in_b_sel))
      B_SEL_RS2:  op_b_s = rs2_val_s;
      B_SEL_FOUR: op_b_s = {{(N-3){1'b0}}, 3'd4};
      default:    op_b_s = in_imm;
    endcase
  end

  alu #(.N(N)) u_alu (
    .ctrl     (in_ctrl),
    .a        (op_a_s),
    .b        (op_b_s),
    .result   (alu_result_s),
    .zero     (alu_zero_s),
    .equal    (alu_equal_s),
    .overflow (alu_ovf_s)
  );

  assign taken_s = branch_taken(br_type_t'(in_br), alu_equal_s, alu_result_s[0]);

  // Next state: flush wins over acceptance, acceptance wins over retire.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else if (accept_s) begin
      state_next_s = ST_FULL;
    end else if ((state_r == ST_FULL) && out_ready) begin
      state_next_s = ST_EMPTY;
    end else begin
      state_next_s = state_r;
    end
  end

  // State, output payload and saturating overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      out_result_r <= {N{1'b0}};
      out_rd_r     <= 5'd0;
      out_taken_r  <= 1'b0;
      out_zero_r   <= 1'b0;
      out_equal_r  <= 1'b0;
      out_ovf_r    <= 1'b0;
      ovf_count_r  <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        out_result_r <= alu_result_s;
        out_rd_r     <= in_rd;
        out_taken_r  <= taken_s;
        out_zero_r   <= alu_zero_s;
        out_equal_r  <= alu_equal_s;
        out_ovf_r    <= alu_ovf_s;
      end
      if (out_valid && out_ready && out_ovf_r && (ovf_count_r != 8'hFF)) begin
        ovf_count_r <= ovf_count_r + 8'd1;
      end
    end
  end

  assign out_result   = out_result_r;
  assign out_rd       = out_rd_r;
  assign out_taken    = out_taken_r;
  assign out_zero     = out_zero_r;
  assign out_equal    = out_equal_r;
  assign out_overflow = out_ovf_r;
  assign ovf_count    = ovf_count_r;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter N, default 32, datapath width in bits.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  decoded instruction present on in_* ports.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 in_ctrl  input  alu_control_t  ALU operation.
REQ-007 in_a_sel  input  2  operand A source: 0 = rs1, 1 = pc, 2 = zero; 3 reserved, treated as zero.
REQ-008 in_b_sel  input  2  operand B source: 0 = rs2, 1 = imm, 2 = constant 4; 3 reserved, treated as imm.
REQ-009 in_rs1, in_rs2, in_rd  input  5 each  register addresses.
REQ-010 in_rs1_data, in_rs2_data, in_pc, in_imm  input  N each  operand values.
REQ-011 in_br  input  3  branch type: 0 none, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, 7 none.
REQ-012 fwd_valid  input  1, fwd_rd  input  5, fwd_data  input  N  writeback forwarding path.
REQ-013 flush  input  1  discard held and incoming instruction.
REQ-014 out_valid  output  1, out_ready  input  1  downstream handshake.
REQ-015 out_result  output  N, out_rd  output  5, out_taken, out_zero, out_equal, out_overflow  output  1 each.
REQ-016 ovf_count  output  8  saturating count of retired overflowing instructions.

Function
REQ-017 Operand A/B SHALL be selected per in_a_sel/in_b_sel; rs1/rs2 values SHALL be replaced by fwd_data when fwd_valid, fwd_rd != 0 and fwd_rd equals the corresponding address.
REQ-018 Selected operands and in_ctrl SHALL drive one combinational alu instance; its result, zero, equal and overflow SHALL be captured into out_* on acceptance.
REQ-019 Two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-020 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-021 Acceptance occurs when in_valid && in_ready && !flush; latency is exactly one cycle (out_valid high the following cycle).
REQ-022 FULL with out_ready && !accept SHALL go EMPTY; FULL with out_ready && accept SHALL stay FULL with new contents; FULL with !out_ready SHALL hold all out_* stable.
REQ-023 flush SHALL force EMPTY next cycle, overriding acceptance and hold; out_* data values are don't-care while out_valid = 0.
REQ-024 out_taken: EQ = equal, NE = !equal, LT/LTU = result[0], GE/GEU = !result[0], otherwise 0; the decoder supplies ALU_SLT/ALU_SLTU for LT/GE/LTU/GEU.
REQ-025 ovf_count SHALL increment by 1 when out_valid && out_ready && out_overflow, saturating at 255 without wrap.
REQ-026 Forwarding with fwd_rd = 0 SHALL never apply; rs data for x0 is used as supplied.

Reset
REQ-027 With rst high at a rising edge: out_valid = 0, all out_* data = 0, ovf_count = 0; rst overrides flush and acceptance.
REQ-028 rst asserted mid-transfer SHALL drop the held instruction without any completion handshake.

Structure
REQ-029 alu_control_t and the a_sel, b_sel and branch-type enums SHALL live in the shared ALU types package; no local redefinitions.
REQ-030 One sub-module: alu (existing), instantiated once; operand muxing, the state register and the counter are local to ex_stage.

Verification
REQ-031 Forwarding: rs1 = 5, rs1_data = 1, fwd_rd = 5, fwd_data = 10, imm = 3, ctrl = ADD, b_sel = imm -> out_result = 13 next cycle.
REQ-032 Backpressure: out_ready = 0 for 3 cycles while FULL -> in_ready = 0 and out_* unchanged; out_ready = 1 -> single retire.
REQ-033 Back-to-back: in_valid and out_ready held high for 4 instructions -> 4 consecutive out_valid cycles, no bubbles.
REQ-034 Branch: ctrl = SLT, a = -1, b = 1, br = LT -> out_taken = 1; br = GE -> out_taken = 0; ctrl = SUB, a = b = 7, br = EQ -> out_taken = 1, out_zero = 1.
REQ-035 Flush and reset: flush while FULL and in_valid -> out_valid = 0 next cycle; rst while FULL -> out_valid = 0, ovf_count = 0.
REQ-036 Overflow counter: 0x7FFFFFFF + 1 ADD retired 260 times -> ovf_count = 255, with out_overflow = 1 on each retire.
